// File: rtl/loc_sram_pkg.sv
// Shared constants, arbiter pointer type and lane placement helpers for the
// local SRAM controller. Lane 0 sits at the MSB end of every row-wide vector.
package loc_sram_pkg;

  localparam int ADDR_SPACE = 4;
  localparam int BW         = 5;
  localparam int D          = 256;

  // Which requester the round-robin pointer currently favours.
  typedef enum logic {
    RR_FAV0 = 1'b0,
    RR_FAV1 = 1'b1
  } rr_ptr_e;

  // Low bit of lane v inside a D*bw wide row vector.
  function automatic int lane_bit_ofs(input int v, input int d, input int bw);
    return (d - 1 - v) * bw;
  endfunction

  // Bit of the per-lane keep mask that belongs to lane v.
  function automatic int lane_mask_idx(input int v, input int d);
    return d - 1 - v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. When both request and merging is
// allowed, both are granted and the pointer stays put; otherwise the pointer
// moves to the requester that did not get the single grant.
module rr_arb2
  import loc_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_merge_ok,
  output logic [1:0] o_gnt
);

  rr_ptr_e r_ptr;
  rr_ptr_e w_ptr_next;

  // Pointer register; after reset requester 0 wins the first collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= RR_FAV0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  // Grant decode and pointer advance.
  always_comb begin
    o_gnt      = 2'b00;
    w_ptr_next = r_ptr;
    case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        if (i_merge_ok) begin
          o_gnt = 2'b11;
        end else if (r_ptr == RR_FAV0) begin
          o_gnt = 2'b01;
        end else begin
          o_gnt = 2'b10;
        end
      end
      default: o_gnt = 2'b00;
    endcase
    if (o_gnt == 2'b01) begin
      w_ptr_next = RR_FAV1;
    end else if (o_gnt == 2'b10) begin
      w_ptr_next = RR_FAV0;
    end
  end

endmodule

// File: rtl/loc_sram_ctrl.sv
// Local SRAM controller: merges/arbitrates two element write requesters onto
// the single masked write port, pipelines row reads with optional
// clear-after-read, and tracks which rows hold data written since a clear.
module loc_sram_ctrl
  import loc_sram_pkg::*;
#(
  parameter int ADDR_SPACE = loc_sram_pkg::ADDR_SPACE,
  parameter int BW         = loc_sram_pkg::BW,
  parameter int D          = loc_sram_pkg::D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_valid,
  output logic                  wr0_ready,
  input  logic [ADDR_SPACE-1:0] wr0_addr,
  input  logic [7:0]            wr0_lane,
  input  logic [BW-1:0]         wr0_data,
  input  logic                  wr1_valid,
  output logic                  wr1_ready,
  input  logic [ADDR_SPACE-1:0] wr1_addr,
  input  logic [7:0]            wr1_lane,
  input  logic [BW-1:0]         wr1_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_SPACE-1:0] rd_addr,
  input  logic                  rd_clr,
  output logic                  rd_rsp_valid,
  output logic [D*BW-1:0]       rd_rsp_data,
  output logic [(1<<ADDR_SPACE)-1:0] row_dirty,
  output logic                  sram_wsb,
  output logic [D-1:0]          sram_bytemask,
  output logic [D*BW-1:0]       sram_wdata,
  output logic [ADDR_SPACE-1:0] sram_waddr,
  output logic [ADDR_SPACE-1:0] sram_raddr,
  input  logic [D*BW-1:0]       sram_rdata
);

  localparam int ROWS = 1 << ADDR_SPACE;

  logic                  w_rd_acc;
  logic                  w_clr_acc;
  logic                  w_merge_ok;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic [D-1:0]          w_mask_next;
  logic [D*BW-1:0]       w_wdata_next;
  logic [ROWS-1:0]       w_dirty_next;

  logic                  r_wsb;
  logic [D-1:0]          r_mask;
  logic [D*BW-1:0]       r_wdata;
  logic [ADDR_SPACE-1:0] r_waddr;
  logic [ADDR_SPACE-1:0] r_raddr;
  logic                  r_rd_pend;
  logic                  r_rsp_valid;
  logic [ROWS-1:0]       r_dirty;

  // Reads are never back-pressured; only reset holds them off.
  assign rd_ready  = ~rst;
  assign w_rd_acc  = rd_valid & rd_ready;
  assign w_clr_acc = w_rd_acc & rd_clr;

  // A clear owns the write port for its cycle, so writers are masked off.
  assign w_req      = {wr1_valid, wr0_valid} & {2{~rst & ~w_clr_acc}};
  assign w_merge_ok = (wr0_addr == wr1_addr) && (wr0_lane != wr1_lane);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_req),
    .i_merge_ok (w_merge_ok),
    .o_gnt      (w_gnt)
  );

  assign wr0_ready = w_gnt[0];
  assign wr1_ready = w_gnt[1];

  // Per-lane mask/data for the next write beat. Lanes that match no grant
  // keep their old contents; a clear zeroes the whole row. Lane numbers at or
  // above D never match, so such grants write nothing.
  for (genvar gi = 0; gi < D; gi++) begin : g_lane
    logic w_hit0;
    logic w_hit1;
    assign w_hit0 = w_gnt[0] && (int'(wr0_lane) == gi);
    assign w_hit1 = w_gnt[1] && (int'(wr1_lane) == gi);
    assign w_mask_next[lane_mask_idx(gi, D)] = ~(w_hit0 | w_hit1) & ~w_clr_acc;
    assign w_wdata_next[lane_bit_ofs(gi, D, BW) +: BW] =
      w_hit0 ? wr0_data : (w_hit1 ? wr1_data : '0);
  end

  // Registered SRAM write pins; a merged grant shares one row so either
  // requester's address is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wsb   <= 1'b1;
      r_mask  <= '1;
      r_wdata <= '0;
      r_waddr <= '0;
    end else begin
      r_wsb   <= ~(w_clr_acc | (|w_gnt));
      r_mask  <= w_mask_next;
      r_wdata <= w_wdata_next;
      if (w_clr_acc) begin
        r_waddr <= rd_addr;
      end else if (w_gnt[0]) begin
        r_waddr <= wr0_addr;
      end else if (w_gnt[1]) begin
        r_waddr <= wr1_addr;
      end
    end
  end

  // Read pipeline: address registered one cycle after accept, response flag
  // one cycle later when the macro presents the row on sram_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr     <= '0;
      r_rd_pend   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_raddr <= rd_addr;
      end
      r_rd_pend   <= w_rd_acc;
      r_rsp_valid <= r_rd_pend;
    end
  end

  // Dirty flags: set by granted writes, cleared by a clear-read of the row.
  always_comb begin
    w_dirty_next = r_dirty;
    if (w_gnt[0]) begin
      w_dirty_next[wr0_addr] = 1'b1;
    end
    if (w_gnt[1]) begin
      w_dirty_next[wr1_addr] = 1'b1;
    end
    if (w_clr_acc) begin
      w_dirty_next[rd_addr] = 1'b0;
    end
  end

  // Dirty flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dirty <= '0;
    end else begin
      r_dirty <= w_dirty_next;
    end
  end

  assign sram_wsb      = r_wsb;
  assign sram_bytemask = r_mask;
  assign sram_wdata    = r_wdata;
  assign sram_waddr    = r_waddr;
  assign sram_raddr    = r_raddr;
  assign rd_rsp_valid  = r_rsp_valid;
  assign rd_rsp_data   = sram_rdata;
  assign row_dirty     = r_dirty;

endmodule

// File: tb/tb_loc_sram_ctrl.sv
// Bench for loc_sram_ctrl: a read-first SRAM macro model plus an
// element-level reference model of row contents, arbitration and dirty flags.
module tb_loc_sram_ctrl;
  import loc_sram_pkg::*;

  localparam int W = D * BW;

  logic          clk;
  logic          rst;
  logic          wr0_valid, wr1_valid, rd_valid, rd_clr;
  logic          wr0_ready, wr1_ready, rd_ready;
  logic [3:0]    wr0_addr, wr1_addr, rd_addr;
  logic [7:0]    wr0_lane, wr1_lane;
  logic [4:0]    wr0_data, wr1_data;
  logic          rd_rsp_valid;
  logic [W-1:0]  rd_rsp_data;
  logic [15:0]   row_dirty;
  logic          sram_wsb;
  logic [D-1:0]  sram_bytemask;
  logic [W-1:0]  sram_wdata;
  logic [3:0]    sram_waddr, sram_raddr;
  logic [W-1:0]  sram_rdata;

  loc_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr),
    .wr0_lane(wr0_lane), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr),
    .wr1_lane(wr1_lane), .wr1_data(wr1_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .row_dirty(row_dirty),
    .sram_wsb(sram_wsb), .sram_bytemask(sram_bytemask), .sram_wdata(sram_wdata),
    .sram_waddr(sram_waddr), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: synchronous read-first, masked write (mask 1 = keep).
  logic [W-1:0] sram_mem [16];
  logic [W-1:0] sram_row;
  logic         sram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int r = 0; r < 16; r++) sram_mem[r] <= '0;
      sram_rdata     <= '0;
      sram_init_done <= 1'b1;
    end else begin
      sram_rdata <= sram_mem[sram_raddr];
      if (!sram_wsb) begin
        sram_row = sram_mem[sram_waddr];
        for (int v = 0; v < D; v++)
          if (!sram_bytemask[v]) sram_row[v*BW +: BW] = sram_wdata[v*BW +: BW];
        sram_mem[sram_waddr] <= sram_row;
      end
    end
  end

  // Reference model: element values per row/lane, favoured requester,
  // dirty flags, and the one read response expected next cycle.
  int           ref_mem [16][D];
  int           ref_fav;
  logic [15:0]  ref_dirty;
  logic         prev_v;
  logic [W-1:0] prev_d;
  logic         obs_r0, obs_r1;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] row_vec(input int r);
    logic [W-1:0] v;
    v = '0;
    for (int l = 0; l < D; l++) v[(D-1-l)*BW +: BW] = 5'(ref_mem[r][l]);
    return v;
  endfunction

  task automatic reset_chk();
    logic [W-1:0] ones;
    ones = '0;
    ones[D-1:0] = '1;
    chk("rst_wsb", W'(sram_wsb), W'(1));
    chk("rst_mask", W'(sram_bytemask), ones);
    chk("rst_wdata", sram_wdata, '0);
    chk("rst_waddr", W'(sram_waddr), '0);
    chk("rst_raddr", W'(sram_raddr), '0);
    chk("rst_rsp_valid", W'(rd_rsp_valid), '0);
    chk("rst_dirty", W'(row_dirty), '0);
    chk("rst_rd_ready", W'(rd_ready), '0);
    chk("rst_wr0_ready", W'(wr0_ready), '0);
    chk("rst_wr1_ready", W'(wr1_ready), '0);
  endtask

  // One clock cycle: drive, check ready at negedge, check pins after the edge.
  task automatic step(input logic v0, input int a0, input int l0, input int d0,
                      input logic v1, input int a1, input int l1, input int d1,
                      input logic rv, input int ra, input logic rc);
    logic clr, g0, g1, wr_any, nowv;
    logic [D-1:0] emask;
    logic [W-1:0] ewdata, nowd;
    int ewaddr;
    wr0_valid = v0; wr0_addr = 4'(a0); wr0_lane = 8'(l0); wr0_data = 5'(d0);
    wr1_valid = v1; wr1_addr = 4'(a1); wr1_lane = 8'(l1); wr1_data = 5'(d1);
    rd_valid = rv; rd_addr = 4'(ra); rd_clr = rc;
    clr = rv && rc;
    g0 = 1'b0; g1 = 1'b0;
    if (!clr) begin
      if (v0 && v1) begin
        if (a0 == a1 && l0 != l1) begin g0 = 1'b1; g1 = 1'b1; end
        else if (ref_fav == 0) g0 = 1'b1;
        else g1 = 1'b1;
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    @(negedge clk);
    obs_r0 = wr0_ready; obs_r1 = wr1_ready;
    chk("wr0_ready", W'(wr0_ready), W'(g0));
    chk("wr1_ready", W'(wr1_ready), W'(g1));
    chk("rd_ready", W'(rd_ready), W'(1));
    wr_any = clr || g0 || g1;
    emask = clr ? '0 : '1;
    ewdata = '0;
    ewaddr = clr ? ra : (g0 ? a0 : a1);
    if (g0) begin emask[D-1-l0] = 1'b0; ewdata[(D-1-l0)*BW +: BW] = 5'(d0); end
    if (g1) begin emask[D-1-l1] = 1'b0; ewdata[(D-1-l1)*BW +: BW] = 5'(d1); end
    nowv = rv;
    nowd = rv ? row_vec(ra) : '0;
    if (g0) begin ref_mem[a0][l0] = d0; ref_dirty[a0] = 1'b1; end
    if (g1) begin ref_mem[a1][l1] = d1; ref_dirty[a1] = 1'b1; end
    if (clr) begin
      for (int l = 0; l < D; l++) ref_mem[ra][l] = 0;
      ref_dirty[ra] = 1'b0;
    end
    if (g0 ^ g1) ref_fav = g0 ? 1 : 0;
    @(posedge clk);
    #1;
    chk("wsb", W'(sram_wsb), W'(!wr_any));
    if (wr_any) begin
      chk("waddr", W'(sram_waddr), W'(ewaddr));
      chk("bytemask", W'(sram_bytemask), W'(emask));
      chk("wdata", sram_wdata, ewdata);
    end
    if (rv) chk("raddr", W'(sram_raddr), W'(ra));
    chk("row_dirty", W'(row_dirty), W'(ref_dirty));
    chk("rsp_valid", W'(rd_rsp_valid), W'(prev_v));
    if (prev_v) chk("rsp_data", rd_rsp_data, prev_d);
    prev_v = nowv;
    prev_d = nowd;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < D; l++) ref_mem[r][l] = 0;
    ref_fav = 0; ref_dirty = '0; prev_v = 1'b0; prev_d = '0;
    rst = 1'b1;
    wr0_valid = 1'b1; wr1_valid = 1'b1; rd_valid = 1'b1; rd_clr = 1'b0;
    wr0_addr = '0; wr1_addr = '0; rd_addr = '0;
    wr0_lane = '0; wr1_lane = 8'd1; wr0_data = '0; wr1_data = '0;
    @(posedge clk); #1;
    reset_chk();
    @(negedge clk);
    rst = 1'b0;
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); #1;

    // Same row, same lane, held: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      step(1, 4, 5, 10 + i, 1, 4, 5, 20 + i, 0, 0, 0);
      chk("alt_gnt0", W'(obs_r0), W'((i % 2) == 0));
      chk("alt_gnt1", W'(obs_r1), W'((i % 2) == 1));
    end

    // Single write to row 3 lane 0.
    step(1, 3, 0, 31, 0, 0, 0, 0, 0, 0, 0);
    chk("w1_mask255", W'(sram_bytemask[255]), W'(0));
    chk("w1_mask_rest", W'(sram_bytemask[254:0]), W'({255{1'b1}}));
    chk("w1_wdata_msb", W'(sram_wdata[1279:1275]), W'(5'h1F));
    chk("w1_dirty3", W'(row_dirty[3]), W'(1));

    // Merge: same row, different lanes.
    step(1, 2, 10, 7, 1, 2, 11, 9, 0, 0, 0);
    chk("merge_r0", W'(obs_r0), W'(1));
    chk("merge_r1", W'(obs_r1), W'(1));
    chk("merge_m245", W'(sram_bytemask[245]), W'(0));
    chk("merge_m244", W'(sram_bytemask[244]), W'(0));
    // Pointer untouched by the merge: requester 1 still favoured.
    step(1, 2, 3, 1, 1, 7, 3, 2, 0, 0, 0);
    chk("post_merge_r1", W'(obs_r1), W'(1));

    // Write then read next cycle.
    step(1, 6, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    idle();
    chk("rd_valid_t2", W'(rd_rsp_valid), W'(1));
    chk("rd_lane0", W'(rd_rsp_data[1279:1275]), W'(3));

    // Clear-read of row 6 with a competing writer.
    step(1, 6, 1, 9, 0, 0, 0, 0, 1, 6, 1);
    chk("clr_blocks_wr0", W'(obs_r0), W'(0));
    idle();
    chk("clr_old_lane0", W'(rd_rsp_data[1279:1275]), W'(3));
    chk("clr_dirty6", W'(row_dirty[6]), W'(0));
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    idle();
    chk("clr_row_zero", rd_rsp_data, '0);

    // Reset with a read in flight: no response afterwards.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    rst = 1'b1;
    wr0_valid = 1'b1; wr1_valid = 1'b1; rd_valid = 1'b1;
    #1;
    reset_chk();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_rsp", W'(rd_rsp_valid), '0);
    end
    @(negedge clk);
    rst = 1'b0;
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0;
    ref_fav = 0; ref_dirty = '0; prev_v = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rsp", W'(rd_rsp_valid), '0);
    idle();
    idle();

    // Randomized traffic over a few rows and lanes to force collisions.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 8 + int'($urandom % 3), int'($urandom % 4), int'($urandom % 32),
           ($urandom % 4) != 0, 8 + int'($urandom % 3), int'($urandom % 4), int'($urandom % 32),
           ($urandom % 2) != 0, 8 + int'($urandom % 3), ($urandom % 6) == 0);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
